binary_fibonacci: RTL and testbench

Converts a 32-bit unsigned binary value into its Zeckendorf (Fibonacci-base) digit vector with a greedy, top-digit-first subtract-and-compare sequencer. Fibonacci weights come from the shared weight ROM through a synchronous read port. The block sits on the encode side of the Fibonacci number path and produces the digit format the Fibonacci-to-binary decoder consumes.

---
 rtl/fib_pkg.sv | 29 ++
 rtl/fib_weight_gen.sv | 35 +++
 rtl/binary_fibonacci.sv | 143 ++++++++++++++
 tb/tb_binary_fibonacci.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci number path: FSM states, data width
// and a Fibonacci helper used for generator seeds and bench expectations.
package fib_pkg;

    localparam int FIB_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMPARE,
        DONE
    } state_t;

    // F(0)=0, F(1)=1, F(2)=1, ...; exact in 32 bits for n <= 47
    function automatic logic [FIB_W-1:0] fibValue(input int n);
        logic [FIB_W-1:0] a;
        logic [FIB_W-1:0] b;
        logic [FIB_W-1:0] t;
        a = '0;
        b = FIB_W'(1);
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

endpackage

// File: rtl/fib_weight_gen.sv
// Downward Fibonacci stepper: after load the current weight is F(NBITS+1),
// and each step moves one index down the sequence.
module fib_weight_gen
    import fib_pkg::*;
#(
    parameter logic [FIB_W-1:0] SEED_A = 32'd0,
    parameter logic [FIB_W-1:0] SEED_B = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    output logic [FIB_W-1:0] o_weight
);

    logic [FIB_W-1:0] r_a;
    logic [FIB_W-1:0] r_b;

    // Pair (a, b) = (F(k), F(k+1)); the weight in use is b - a = F(k-1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= SEED_A;
            r_b <= SEED_B;
        end else if (i_step) begin
            r_a <= r_b - r_a;
            r_b <= r_a;
        end
    end

    assign o_weight = r_b - r_a;

endmodule

// File: rtl/binary_fibonacci.sv
// Binary to Zeckendorf encoder using a greedy top-digit-first sequencer.
// Define FIB_INTERNAL_GEN_EN to generate weights locally instead of reading the ROM.
module binary_fibonacci
    import fib_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_convert,
    input  logic [FIB_W-1:0] input_b,
    output logic [5:0]       fib_addr,
    input  logic [FIB_W-1:0] fib_data,
    output logic             busy,
    output logic             convert_done,
    output logic [NBITS-1:0] f_out,
    output logic             overflow
);

    localparam logic [5:0] TOP_IDX = 6'(NBITS - 1);

    state_t           r_state;
    logic [FIB_W-1:0] r_rem;
    logic [NBITS-1:0] r_work;
    logic [5:0]       r_idx;
    logic             r_prevSet;
    logic             r_ovf;
    logic [5:0]       r_fibAddr;
    logic             r_busy;
    logic             r_done;
    logic [NBITS-1:0] r_fOut;
    logic             r_overflow;

    logic [FIB_W-1:0] w_weight;
    logic             w_take;
    logic [NBITS-1:0] w_digitMask;
    logic             w_finalOvf;

`ifdef FIB_INTERNAL_GEN_EN
    logic w_unusedRom;

    assign w_unusedRom = ^fib_data;

    fib_weight_gen #(
        .SEED_A(fibValue(NBITS + 2)),
        .SEED_B(fibValue(NBITS + 3))
    ) u_weightGen (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == IDLE && en_convert),
        .i_step  (r_state == COMPARE),
        .o_weight(w_weight)
    );
`else
    assign w_weight = fib_data;
`endif

    assign w_take      = (r_rem >= w_weight);
    assign w_digitMask = NBITS'(1) << r_idx;
    assign w_finalOvf  = r_ovf || (r_rem != '0);

    // Sequencer; r_prevSet remembers whether digit idx+1 was set, so two
    // adjacent ones flag an input too large for NBITS digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_work     <= '0;
            r_idx      <= '0;
            r_prevSet  <= 1'b0;
            r_ovf      <= 1'b0;
            r_fibAddr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fOut     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fibAddr <= '0;
                    r_busy    <= en_convert;
                    if (en_convert) begin
                        r_rem     <= input_b;
                        r_work    <= '0;
                        r_idx     <= TOP_IDX;
                        r_prevSet <= 1'b0;
                        r_ovf     <= 1'b0;
`ifdef FIB_INTERNAL_GEN_EN
                        r_state   <= COMPARE;
`else
                        r_state   <= FETCH;
                        r_fibAddr <= TOP_IDX;
`endif
                    end
                end
                FETCH: begin
                    r_state <= COMPARE;
                end
                COMPARE: begin
                    r_prevSet <= w_take;
                    if (w_take) begin
                        r_rem  <= r_rem - w_weight;
                        r_work <= r_work | w_digitMask;
                        if (r_prevSet) begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (r_idx == '0) begin
                        r_state   <= DONE;
                        r_fibAddr <= '0;
                    end else begin
                        r_idx <= r_idx - 6'd1;
`ifdef FIB_INTERNAL_GEN_EN
                        r_state <= COMPARE;
`else
                        r_state   <= FETCH;
                        r_fibAddr <= r_idx - 6'd1;
`endif
                    end
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b1;
                    r_fibAddr  <= '0;
                    r_overflow <= w_finalOvf;
                    r_fOut     <= w_finalOvf ? '0 : r_work;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fib_addr     = r_fibAddr;
    assign busy         = r_busy;
    assign convert_done = r_done;
    assign f_out        = r_fOut;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_binary_fibonacci.sv
// Directed bench for binary_fibonacci (NBITS=32) with a synchronous weight ROM model.
module tb_binary_fibonacci;
    import fib_pkg::*;

`ifdef FIB_INTERNAL_GEN_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif

    logic        clk;
    logic        rst;
    logic        enConvert;
    logic [31:0] inputB;
    logic [5:0]  fibAddr;
    logic [31:0] fibData;
    logic        busy;
    logic        convertDone;
    logic [31:0] fOut;
    logic        overflow;

    int total;
    int bad;
    int latency;

    binary_fibonacci #(.NBITS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_convert  (enConvert),
        .input_b     (inputB),
        .fib_addr    (fibAddr),
        .fib_data    (fibData),
        .busy        (busy),
        .convert_done(convertDone),
        .f_out       (fOut),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight ROM: address i holds F(i+2), one cycle read latency
    always @(posedge clk) begin
`ifdef FIB_INTERNAL_GEN_EN
        fibData <= 32'hDEAD_BEEF;
`else
        fibData <= fibValue(int'(fibAddr) + 2);
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns edges from sampling edge to the done cycle
    task automatic applyStimulus(input logic [31:0] value, output int lat);
        enConvert = 1'b1;
        inputB    = value;
        @(posedge clk);
        @(negedge clk);
        enConvert = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (convertDone) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] value,
                           input logic [31:0] expF, input logic expOvf);
        int lat;
        applyStimulus(value, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
        checkOutput({tag, "_fout"}, fOut, expF);
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, expOvf});
        checkOutput({tag, "_busyInDone"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput({tag, "_busyAfter"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic sawDone;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        enConvert = 1'b0;
        inputB    = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_fout", fOut, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("rst_done", {31'd0, convertDone}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_addr", {26'd0, fibAddr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed conversions");
        runCase("zero", 32'd0, 32'h0000_0000, 1'b0);
        runCase("v100", 32'd100, 32'h0000_0214, 1'b0);
        runCase("v4", 32'd4, 32'h0000_0005, 1'b0);
        runCase("maxOk", 32'd5702886, 32'hAAAA_AAAA, 1'b0);
        runCase("v100b", 32'd100, 32'h0000_0214, 1'b0);
        runCase("firstOvf", 32'd5702887, 32'h0000_0000, 1'b1);
        runCase("allOnes", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        checkOutput("idle_addr", {26'd0, fibAddr}, 32'd0);

        $display("[TB] start pulsed mid-conversion");
        enConvert = 1'b1;
        inputB    = 32'd100;
        @(posedge clk);
        @(negedge clk);
        enConvert = 1'b0;
        repeat (9) @(negedge clk);
        enConvert = 1'b1;
        inputB    = 32'd4;
        @(negedge clk);
        enConvert = 1'b0;
        lat = -1;
        for (int k = 11; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (convertDone) begin
                lat = k;
                break;
            end
        end
        checkOutput("midPulse_latency", 32'(lat), 32'(LAT));
        checkOutput("midPulse_fout", fOut, 32'h0000_0214);
        sawDone = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (convertDone) sawDone = 1'b1;
        end
        checkOutput("midPulse_noSecondDone", {31'd0, sawDone}, 32'd0);

        $display("[TB] earliest restart in done cycle");
        enConvert = 1'b1;
        inputB    = 32'd4;
        @(posedge clk);
        @(negedge clk);
        enConvert = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (convertDone) break;
        end
        applyStimulus(32'd100, lat);
        checkOutput("restart_latency", 32'(lat), 32'(LAT));
        checkOutput("restart_fout", fOut, 32'h0000_0214);
        @(negedge clk);

        $display("[TB] reset mid-conversion");
        enConvert = 1'b1;
        inputB    = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        enConvert = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midRst_fout", fOut, 32'd0);
        checkOutput("midRst_addr", {26'd0, fibAddr}, 32'd0);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (convertDone || busy) sawDone = 1'b1;
        end
        checkOutput("midRst_quiet", {31'd0, sawDone}, 32'd0);
        runCase("afterRst", 32'd100, 32'h0000_0214, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
